// File: rtl/sram32_sched_pkg.sv
// Shared widths, bank-index helper and response-count type
// for the banked SRAM scheduler.
package sram32_sched_pkg;

    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 32;
    localparam int BANK_LSB = 13;
    localparam int BANK_W   = ADDR_W - BANK_LSB;

    typedef logic [BANK_W-1:0] bank_t;
    typedef logic [1:0]        resp_cnt_t;

    function automatic bank_t bank_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:BANK_LSB];
    endfunction

endpackage

// File: rtl/sram32_sched_resp_fifo.sv
// Two-entry read-response buffer; the scheduler's credit
// rule keeps pushes away from a full buffer.
module sram32_sched_resp_fifo
    import sram32_sched_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output resp_cnt_t         occ
);

    logic [DATA_W-1:0] mem [2];
    logic              wptr;
    logic              rptr;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wptr <= 1'b0;
            rptr <= 1'b0;
            occ  <= '0;
        end else begin
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
            unique case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign dout = mem[rptr];

endmodule

// File: rtl/sram32_bank_sched.sv
// Write/read arbiter for the 16-bank SRAM wrapper with
// anti-starvation, response credits and conflict statistics.
module sram32_bank_sched
    import sram32_sched_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int RESP_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] wr_mask,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              CE0,
    output logic [ADDR_W-1:0] A0,
    output logic [DATA_W-1:0] D0,
    output logic              WE0,
    output logic [DATA_W-1:0] WEM0,
    output logic              CE1,
    output logic [ADDR_W-1:0] A1,
    input  logic [DATA_W-1:0] Q1,
    output logic [15:0]       conflict_cnt
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam resp_cnt_t CREDITS = resp_cnt_t'(RESP_DEPTH);

    logic [SW-1:0] starve;
    logic          inflight;
    resp_cnt_t     occ;
    logic          pop;
    logic [2:0]    cnt;
    logic          credit_ok;
    logic          wc;
    logic          rc;
    logic          conflict;
    logic          write_turn;
    logic          wr_issue;
    logic          rd_issue;

    assign rdata_valid = (occ != '0) & ~RST;
    assign pop         = rdata_valid & rdata_ready;

    // Outstanding responses once this cycle's pop retires
    assign cnt = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    assign credit_ok = cnt < {1'b0, CREDITS};

    assign wc = wr_valid & ~RST;
    assign rc = rd_valid & credit_ok & ~RST;

    assign conflict = wc & rc
                    & (bank_of(wr_addr) == bank_of(rd_addr));
    assign write_turn = starve >= STARVE_LIM;

    always_comb begin
        wr_issue = 1'b0;
        rd_issue = 1'b0;
        unique case (1'b1)
            conflict & write_turn:  wr_issue = 1'b1;
            conflict & ~write_turn: rd_issue = 1'b1;
            default: begin
                wr_issue = wc;
                rd_issue = rc;
            end
        endcase
    end

    assign wr_ready = wr_issue;
    assign rd_ready = rd_issue;
    assign CE0  = wr_issue;
    assign WE0  = wr_issue;
    assign A0   = wr_issue ? wr_addr : '0;
    assign D0   = wr_issue ? wr_data : '0;
    assign WEM0 = wr_issue ? wr_mask : '0;
    assign CE1  = rd_issue;
    assign A1   = rd_issue ? rd_addr : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            starve       <= '0;
            inflight     <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            inflight <= rd_issue;
            if (wr_issue) begin
                starve <= '0;
            end else if (conflict) begin
                starve <= starve + 1'b1;
            end
            if (conflict && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

    sram32_sched_resp_fifo u_fifo (
        .CLK  (CLK),
        .RST  (RST),
        .push (inflight & ~RST),
        .pop  (pop),
        .din  (Q1),
        .dout (rdata),
        .occ  (occ)
    );

endmodule

// File: tb/tb_sram32_bank_sched.sv
// Scenario bench for sram32_bank_sched with an SRAM model
// and a read-response scoreboard.
module tb_sram32_bank_sched;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [16:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] wr_mask = '0;
    logic        rd_valid = 1'b0;
    logic        rd_ready;
    logic [16:0] rd_addr = '0;
    logic        rdata_valid;
    logic        rdata_ready = 1'b1;
    logic [31:0] rdata;
    logic        CE0, WE0, CE1;
    logic [16:0] A0, A1;
    logic [31:0] D0, WEM0;
    logic [31:0] Q1 = '0;
    logic [15:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] sram    [int];
    logic [31:0] ref_mem [int];
    logic [31:0] exp_q   [$];
    logic [31:0] exp_v;

    always #5 CLK = ~CLK;

    sram32_bank_sched dut (
        .CLK          (CLK),
        .RST          (RST),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_mask      (wr_mask),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_addr      (rd_addr),
        .rdata_valid  (rdata_valid),
        .rdata_ready  (rdata_ready),
        .rdata        (rdata),
        .CE0          (CE0),
        .A0           (A0),
        .D0           (D0),
        .WE0          (WE0),
        .WEM0         (WEM0),
        .CE1          (CE1),
        .A1           (A1),
        .Q1           (Q1),
        .conflict_cnt (conflict_cnt)
    );

    // SRAM: read sees the contents from before a same-cycle write
    always @(posedge CLK) begin
        if (CE1) begin
            Q1 <= sram.exists(int'(A1)) ? sram[int'(A1)] : 32'h0;
        end
        if (CE0 && WE0) begin
            sram[int'(A0)] = ((sram.exists(int'(A0)) ?
                              sram[int'(A0)] : 32'h0) & ~WEM0)
                           | (D0 & WEM0);
        end
    end

    function automatic logic [31:0] ref_rd(input logic [16:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
    endfunction

    // Scoreboard: expected data taken from the request-side model
    always @(negedge CLK) begin
        if (!RST) begin
            if (rdata_valid && rdata_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected got=%h", rdata);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (rdata !== exp_v) begin
                        errors++;
                        if (errors < 20)
                            $display("FAIL resp_data got=%h exp=%h",
                                     rdata, exp_v);
                    end
                end
            end
            if (rd_ready) exp_q.push_back(ref_rd(rd_addr));
            if (wr_ready) begin
                ref_mem[int'(wr_addr)] = (ref_rd(wr_addr) & ~wr_mask)
                                       | (wr_data & wr_mask);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic do_write(input logic [16:0] a,
                            input logic [31:0] d,
                            input logic [31:0] m);
        int n = 0;
        step();
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_mask  = m;
        @(negedge CLK);
        while (!wr_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (!wr_ready) begin
            errors++;
            $display("FAIL write_accept got=0 exp=1 addr=%h", a);
        end
        step();
        wr_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        int k = 0;
        rd_valid = 1'b0;
        wr_valid = 1'b0;
        rdata_ready = 1'b1;
        while (exp_q.size() != 0 && k < n) begin
            step();
            k++;
        end
        repeat (2) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        wr_valid = 1'b1;
        wr_addr = 17'h00010;
        rd_valid = 1'b1;
        rd_addr = 17'h02000;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({wr_ready, rd_ready, CE0, CE1, WE0, rdata_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=000000",
                     {wr_ready, rd_ready, CE0, CE1, WE0, rdata_valid});
        end
        checks++;
        if (conflict_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_cnt got=%h exp=0000", conflict_cnt);
        end
        step();
        RST = 1'b0;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
    endtask

    task automatic test_parallel();
        int lat = 1;
        step();
        wr_valid = 1'b1;
        wr_addr = 17'h00010;
        wr_data = 32'hA5A5A5A5;
        wr_mask = 32'hFFFFFFFF;
        rd_valid = 1'b1;
        rd_addr = 17'h02000;
        @(negedge CLK);
        checks++;
        if ({wr_ready, rd_ready, CE0, CE1, WE0} !== 5'b11111) begin
            errors++;
            $display("FAIL par_issue got=%b exp=11111",
                     {wr_ready, rd_ready, CE0, CE1, WE0});
        end
        checks++;
        if (A0 !== 17'h00010 || A1 !== 17'h02000 || D0 !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL par_addr got=%h/%h/%h exp=00010/02000/a5a5a5a5",
                     A0, A1, D0);
        end
        step();
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (CE0 !== 1'b0 || A0 !== '0 || D0 !== '0 || A1 !== '0) begin
            errors++;
            $display("FAIL idle_zero got=%b/%h/%h/%h exp=0",
                     CE0, A0, D0, A1);
        end
        while (!rdata_valid && lat < 6) begin
            @(negedge CLK);
            lat++;
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL par_latency got=%0d exp=2", lat);
        end
        checks++;
        if (conflict_cnt !== 16'h0) begin
            errors++;
            $display("FAIL par_cnt got=%h exp=0000", conflict_cnt);
        end
        drain(10);
    endtask

    task automatic test_mask();
        int n = 0;
        do_write(17'h1ABCD, 32'h12345678, 32'hFFFFFFFF);
        do_write(17'h1ABCD, 32'hDEADBEEF, 32'h0000FFFF);
        step();
        rd_valid = 1'b1;
        rd_addr = 17'h1ABCD;
        @(negedge CLK);
        while (!rd_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        step();
        rd_valid = 1'b0;
        n = 0;
        @(negedge CLK);
        while (!rdata_valid && n < 10) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (rdata_valid !== 1'b1 || rdata !== 32'h1234BEEF) begin
            errors++;
            $display("FAIL mask_merge got=%h v=%b exp=1234beef",
                     rdata, rdata_valid);
        end
        drain(10);
    endtask

    task automatic test_starve();
        pulse_reset();
        rdata_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1;
            wr_addr = 17'h06100;
            wr_data = 32'h5151_0000 + 32'(i);
            wr_mask = 32'hFFFFFFFF;
            rd_valid = 1'b1;
            rd_addr = 17'h06000 + 17'(i);
            @(negedge CLK);
            checks++;
            if (rd_ready !== (i < 4) || wr_ready !== (i == 4)) begin
                errors++;
                $display("FAIL starve_c%0d got=r%b w%b exp=r%b w%b",
                         i, rd_ready, wr_ready, i < 4, i == 4);
            end
            step();
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        @(negedge CLK);
        checks++;
        if (conflict_cnt !== 16'd5) begin
            errors++;
            $display("FAIL starve_cnt got=%0d exp=5", conflict_cnt);
        end
        drain(10);
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int k = 0;
        for (int i = 0; i < 4; i++)
            do_write(17'h0A000 + 17'(i), 32'hC0DE0000 + 32'(i),
                     32'hFFFFFFFF);
        step();
        rdata_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rd_valid = 1'b1;
            rd_addr = 17'h0A000 + 17'(k % 4);
            @(negedge CLK);
            if (rd_ready) begin
                acc++;
                k++;
            end
            step();
        end
        checks++;
        if (acc != 2) begin
            errors++;
            $display("FAIL bp_credit got=%0d exp=2", acc);
        end
        rdata_ready = 1'b1;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            rd_valid = 1'b1;
            rd_addr = 17'h0A000 + 17'(k % 4);
            @(negedge CLK);
            if (rd_ready) begin
                acc++;
                k++;
            end
            step();
        end
        checks++;
        if (acc != 8) begin
            errors++;
            $display("FAIL bp_resume got=%0d exp=8", acc);
        end
        drain(10);
    endtask

    task automatic test_reset_inflight();
        int bad = 0;
        step();
        rd_valid = 1'b1;
        rd_addr = 17'h0A001;
        @(negedge CLK);
        checks++;
        if (rd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_rd_issue got=%b exp=1", rd_ready);
        end
        step();
        RST = 1'b1;
        wr_valid = 1'b1;
        wr_addr = 17'h0A100;
        rd_addr = 17'h0A002;
        @(negedge CLK);
        checks++;
        if ({wr_ready, rd_ready, CE0, CE1, WE0, rdata_valid} !== 6'b0) begin
            errors++;
            $display("FAIL rst_gate got=%b exp=000000",
                     {wr_ready, rd_ready, CE0, CE1, WE0, rdata_valid});
        end
        step();
        RST = 1'b0;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (rdata_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_stale got=%0d cycles exp=0", bad);
        end
        checks++;
        if (conflict_cnt !== 16'h0) begin
            errors++;
            $display("FAIL rst_cnt got=%h exp=0000", conflict_cnt);
        end
        exp_q.delete();
    endtask

    task automatic test_saturate();
        int bad = 0;
        pulse_reset();
        rdata_ready = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            wr_valid = 1'b1;
            wr_addr = 17'h0E004;
            wr_data = 32'(i);
            wr_mask = 32'hFFFFFFFF;
            rd_valid = 1'b1;
            rd_addr = 17'h0E000;
            @(negedge CLK);
            if (wr_ready !== ((i % 5) == 4) || rd_ready !== ((i % 5) != 4))
                bad++;
            if (i == 1000) begin
                checks++;
                if (conflict_cnt !== 16'd1000) begin
                    errors++;
                    $display("FAIL sat_mid got=%0d exp=1000", conflict_cnt);
                end
            end
            if (i == 65535 || i == 69999) begin
                checks++;
                if (conflict_cnt !== 16'hFFFF) begin
                    errors++;
                    $display("FAIL sat_hold i=%0d got=%h exp=ffff",
                             i, conflict_cnt);
                end
            end
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sat_pattern got=%0d bad cycles exp=0", bad);
        end
        drain(10);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_parallel();
        test_mask();
        test_starve();
        test_backpressure();
        test_reset_inflight();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
